router_ingress_ctrl: RTL and testbench
======================================

// Module: router_ingress_ctrl
// PURPOSE
// Ingress controller of the 1x3 router; sits directly upstream of the three router_fifo instances.
// Accepts byte-serial packets from the source, decodes the destination and drives that FIFO's write_enb/data_in/lfd_state.
// Computes and checks packet parity, and applies flow control via busy.
// Also generates per-FIFO vld_out and the soft_reset read-timeout pulses that the FIFOs consume.
// PARAMETERS
// TIMEOUT  30  cycles a non-empty FIFO may go unread before its soft_reset pulses
// PORTS
// clock       in   1  rising-edge clock
// resetn      in   1  synchronous, active-low reset
// pkt_valid   in   1  data_in carries a valid packet byte
// data_in     in   8  packet byte stream: header, payload, parity
// fifo_full   in   3  full flags of FIFO0..2
// fifo_empty  in   3  empty flags of FIFO0..2
// read_enb    in   3  downstream read enables of FIFO0..2
// busy        out  1  source must hold data_in while high
// write_enb   out  3  one-hot FIFO write enable (combinational)
// dout        out  8  byte to FIFO data_in (combinational)
// lfd_state   out  1  high with the header write (combinational)
// err         out  1  one-cycle pulse on parity mismatch, bad address or aborted packet (registered)
// vld_out     out  3  ~fifo_empty (combinational)
// soft_reset  out  3  one-cycle timeout pulse per FIFO (registered)
// BEHAVIOUR
// - Packet format: header {len[7:2], addr[1:0]}, then len payload bytes, then parity = XOR of header and all payload bytes.
// - A byte is accepted at a rising edge when pkt_valid=1 and busy=0.
// - Reset (resetn=0 at an edge): state IDLE; rem/hdr/parity registers 0; err=0; soft_reset=0; timeout counters 0.
// - Outputs then follow the state: busy=0, write_enb=0, dout=0, lfd_state=0.
// - IDLE: busy=0. On an accepted header, latch hdr, addr and rem=len, and start parity with the header.
//   - addr=3: pulse err, load rem=len+1, go to DROP.
//   - otherwise: if fifo_empty[addr]=1 go to LOAD_HDR, else go to WAIT_EMPTY.
// - WAIT_EMPTY: busy=1. Go to LOAD_HDR in the cycle after fifo_empty[addr]=1.
// - LOAD_HDR: lasts exactly one cycle. busy=1, write_enb[addr]=1, dout=hdr, lfd_state=1.
//   - Next state is LOAD_DATA if len>0, else LOAD_PARITY.
// - LOAD_DATA: busy=fifo_full[addr]. Write is pass-through, zero latency.
//   - When pkt_valid=1 and busy=0: write_enb[addr]=1, dout=data_in, parity^=data_in, rem--.
//   - When rem reaches 0, go to LOAD_PARITY.
// - LOAD_PARITY: busy=fifo_full[addr]. The accepted byte is written like a payload byte.
//   - If it differs from the computed parity, pulse err on the next cycle.
//   - The parity byte is written to the FIFO either way. Then return to IDLE.
// - fifo_full high: no write and no acceptance; the source holds the byte, and no byte is lost or duplicated.
// - DROP: busy=0. Accepted bytes are discarded, rem-- per byte; go to IDLE when rem reaches 0. No writes occur.
// - soft_reset[addr] in WAIT_EMPTY, LOAD_HDR, LOAD_DATA or LOAD_PARITY:
//   - WAIT_EMPTY or LOAD_HDR: go to LOAD_HDR next cycle, because the FIFO is now cleared.
//   - LOAD_DATA or LOAD_PARITY: pulse err, load rem = bytes still owed (payload remaining + 1 parity), go to DROP.
// - Timeout, per FIFO i, 5-bit counter:
//   - Clears when read_enb[i]=1 or vld_out[i]=0; otherwise increments.
//   - When it equals TIMEOUT-1 with vld_out[i]=1 and read_enb[i]=0: soft_reset[i]=1 on the next cycle and the counter clears.
// - Only one write_enb bit is ever high. dout=0 whenever write_enb=0.
// TESTING
// - Packet 0x0D,0x11,0x22,0x33,0x0D with all FIFOs empty:
//   - write_enb=3'b010 for 5 cycles in the order 0x0D(lfd_state=1),0x11,0x22,0x33,0x0D; err stays 0.
// - Same packet with the last byte 0xFF: 0xFF is written, then err pulses once; state returns to IDLE.
// - Header 0x0B (addr 3, len 2) + 3 bytes: no write_enb, err pulses once, busy stays 0; the next header decodes normally.
// - Addr 0, len 4, fifo_full[0]=1 for 4 cycles after payload byte 2:
//   - busy=1 and write_enb=0 during the stall; payload bytes 3-4 and parity are written afterwards, unchanged.
// - fifo_empty[2]=0, read_enb[2]=0 held: soft_reset[2] pulses exactly 30 cycles later.
//   - A read_enb[2] pulse at cycle 29 restarts the count.
// - Header to non-empty FIFO1: busy=1 in WAIT_EMPTY; a soft_reset[1] timeout releases it to LOAD_HDR.
//   - resetn=0 mid-payload: all outputs 0 and IDLE next cycle.

Source files
------------

// File: rtl/router_ingress_ctrl.sv
// Ingress controller of the 1x3 router: decodes packet headers, steers bytes into one of three
// FIFOs, checks parity, applies flow control and generates per-FIFO read-timeout soft resets.
module router_ingress_ctrl #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic       busy,
  output logic [2:0] write_enb,
  output logic [7:0] dout,
  output logic       lfd_state,
  output logic       err,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitEmpty,
    StLoadHdr,
    StLoadData,
    StLoadParity,
    StDrop
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      hdr_q, hdr_d;
  logic [6:0]      rem_q, rem_d;
  logic [7:0]      parity_q, parity_d;
  logic            err_q, err_d;
  logic [2:0]      soft_reset_q, soft_reset_d;
  logic [2:0][4:0] cnt_q, cnt_d;

  logic [1:0] addr;
  logic [5:0] len;
  logic [3:0] full_ext, empty_ext, srst_ext;
  logic       full_sel, empty_sel, srst_sel;
  logic       accept, wr;

  assign addr = hdr_q[1:0];
  assign len  = hdr_q[7:2];

  // Padded to four entries so addr=3 selects a harmless zero.
  assign full_ext  = {1'b0, fifo_full};
  assign empty_ext = {1'b0, fifo_empty};
  assign srst_ext  = {1'b0, soft_reset_q};
  assign full_sel  = full_ext[addr];
  assign empty_sel = empty_ext[addr];
  assign srst_sel  = srst_ext[addr];

  assign busy = (state_q == StWaitEmpty) || (state_q == StLoadHdr) ||
                (((state_q == StLoadData) || (state_q == StLoadParity)) && full_sel);
  assign accept = pkt_valid && !busy;

  assign write_enb  = wr ? (3'b001 << addr) : 3'b000;
  assign err        = err_q;
  assign soft_reset = soft_reset_q;
  assign vld_out    = ~fifo_empty;

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    rem_d     = rem_q;
    parity_d  = parity_q;
    err_d     = 1'b0;
    wr        = 1'b0;
    dout      = 8'h00;
    lfd_state = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          hdr_d    = data_in;
          parity_d = data_in;
          rem_d    = {1'b0, data_in[7:2]};
          if (data_in[1:0] == 2'd3) begin
            err_d   = 1'b1;
            rem_d   = {1'b0, data_in[7:2]} + 7'd1;
            state_d = StDrop;
          end else if (empty_ext[data_in[1:0]]) begin
            state_d = StLoadHdr;
          end else begin
            state_d = StWaitEmpty;
          end
        end
      end
      StWaitEmpty: begin
        if (empty_sel || srst_sel) state_d = StLoadHdr;
      end
      StLoadHdr: begin
        wr        = 1'b1;
        dout      = hdr_q;
        lfd_state = 1'b1;
        // A soft reset here wiped the FIFO, so the header is simply rewritten.
        if (srst_sel)         state_d = StLoadHdr;
        else if (len != 6'd0) state_d = StLoadData;
        else                  state_d = StLoadParity;
      end
      StLoadData: begin
        if (srst_sel) begin
          // Packet is lost: swallow the remaining payload plus parity.
          err_d   = 1'b1;
          rem_d   = rem_q + 7'd1 - {6'd0, accept};
          state_d = StDrop;
        end else if (accept) begin
          wr       = 1'b1;
          dout     = data_in;
          parity_d = parity_q ^ data_in;
          rem_d    = rem_q - 7'd1;
          if (rem_q == 7'd1) state_d = StLoadParity;
        end
      end
      StLoadParity: begin
        if (srst_sel) begin
          err_d   = 1'b1;
          rem_d   = accept ? 7'd0 : 7'd1;
          state_d = accept ? StIdle : StDrop;
        end else if (accept) begin
          wr      = 1'b1;
          dout    = data_in;
          err_d   = (data_in != parity_q);
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (accept) begin
          rem_d = rem_q - 7'd1;
          if (rem_q == 7'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    soft_reset_d = 3'b000;
    cnt_d        = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (read_enb[i] || !vld_out[i]) begin
        cnt_d[i] = 5'd0;
      end else if (cnt_q[i] == 5'(TIMEOUT - 1)) begin
        cnt_d[i]        = 5'd0;
        soft_reset_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 5'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= StIdle;
      hdr_q        <= 8'h00;
      rem_q        <= 7'd0;
      parity_q     <= 8'h00;
      err_q        <= 1'b0;
      soft_reset_q <= 3'b000;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      rem_q        <= rem_d;
      parity_q     <= parity_d;
      err_q        <= err_d;
      soft_reset_q <= soft_reset_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// Directed bench for router_ingress_ctrl: packets, parity error, bad address drop, back-pressure,
// read timeout and soft-reset release of a waiting header, and mid-packet reset.
module tb_router_ingress_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic       busy;
  logic [2:0] write_enb;
  logic [7:0] dout;
  logic       lfd_state;
  logic       err;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;

  int n_pass  = 0;
  int n_total = 0;

  router_ingress_ctrl #(.TIMEOUT(30)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .read_enb   (read_enb),
    .busy       (busy),
    .write_enb  (write_enb),
    .dout       (dout),
    .lfd_state  (lfd_state),
    .err        (err),
    .vld_out    (vld_out),
    .soft_reset (soft_reset)
  );

  always #5 clock = ~clock;

  // Outputs packed as {write_enb, dout, lfd_state, busy, err}.
  task automatic test_reset();
    resetn = 1'b0; pkt_valid = 1'b1; data_in = 8'h0D;
    @(negedge clock); @(negedge clock); #1;
    n_total++;
    if ({write_enb, dout, lfd_state, busy, err, soft_reset, vld_out} !== 20'h0)
      $display("FAIL reset: got %h want 00000",
               {write_enb, dout, lfd_state, busy, err, soft_reset, vld_out});
    else n_pass++;
    resetn = 1'b1; pkt_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_good_packet();
    logic [7:0] din [8] = '{8'h0D, 8'h11, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00, 8'h00};
    logic       vl  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] ewe [8] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
    logic [7:0] edo [8] = '{8'h00, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00, 8'h00};
    logic       elf [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ebs [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 8; c++) begin
      pkt_valid = vl[c]; data_in = din[c]; #1;
      n_total++;
      if ({write_enb, dout, lfd_state, busy, err} !== {ewe[c], edo[c], elf[c], ebs[c], 1'b0})
        $display("FAIL good_pkt cyc %0d: got %h want %h", c,
                 {write_enb, dout, lfd_state, busy, err},
                 {ewe[c], edo[c], elf[c], ebs[c], 1'b0});
      else n_pass++;
      @(negedge clock);
    end
  endtask

  task automatic test_bad_parity();
    logic [7:0] din [8] = '{8'h0D, 8'h11, 8'h11, 8'h22, 8'h33, 8'hFF, 8'h00, 8'h00};
    logic       vl  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] ewe [8] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
    logic [7:0] edo [8] = '{8'h00, 8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF, 8'h00, 8'h00};
    logic       elf [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ebs [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       eer [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 8; c++) begin
      pkt_valid = vl[c]; data_in = din[c]; #1;
      n_total++;
      if ({write_enb, dout, lfd_state, busy, err} !== {ewe[c], edo[c], elf[c], ebs[c], eer[c]})
        $display("FAIL bad_parity cyc %0d: got %h want %h", c,
                 {write_enb, dout, lfd_state, busy, err},
                 {ewe[c], edo[c], elf[c], ebs[c], eer[c]});
      else n_pass++;
      @(negedge clock);
    end
  endtask

  task automatic test_bad_addr_drop();
    logic [7:0] din [8] = '{8'h0B, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h02, 8'h02, 8'h00};
    logic       vl  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] ewe [8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000};
    logic [7:0] edo [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h00};
    logic       elf [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       ebs [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       eer [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 8; c++) begin
      pkt_valid = vl[c]; data_in = din[c]; #1;
      n_total++;
      if ({write_enb, dout, lfd_state, busy, err} !== {ewe[c], edo[c], elf[c], ebs[c], eer[c]})
        $display("FAIL bad_addr cyc %0d: got %h want %h", c,
                 {write_enb, dout, lfd_state, busy, err},
                 {ewe[c], edo[c], elf[c], ebs[c], eer[c]});
      else n_pass++;
      @(negedge clock);
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] din [12] = '{8'h10, 8'h01, 8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h03,
                             8'h03, 8'h04, 8'h14, 8'h00};
    logic       vl  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b1, 1'b1, 1'b1, 1'b0};
    logic       ful [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0] ewe [12] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000,
                             3'b001, 3'b001, 3'b001, 3'b000};
    logic [7:0] edo [12] = '{8'h00, 8'h10, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h03, 8'h04, 8'h14, 8'h00};
    logic       elf [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0};
    logic       ebs [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b0, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 12; c++) begin
      pkt_valid = vl[c]; data_in = din[c]; fifo_full = {2'b00, ful[c]}; #1;
      n_total++;
      if ({write_enb, dout, lfd_state, busy, err} !== {ewe[c], edo[c], elf[c], ebs[c], 1'b0})
        $display("FAIL back_pressure cyc %0d: got %h want %h", c,
                 {write_enb, dout, lfd_state, busy, err},
                 {ewe[c], edo[c], elf[c], ebs[c], 1'b0});
      else n_pass++;
      @(negedge clock);
    end
    fifo_full = 3'b000;
  endtask

  task automatic test_timeout();
    fifo_empty = 3'b011; read_enb = 3'b000; pkt_valid = 1'b0; #1;
    n_total++;
    if (vld_out !== 3'b100) $display("FAIL timeout_vld: got %b want 100", vld_out);
    else n_pass++;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clock); #1;
      n_total++;
      if (soft_reset !== {(k == 30 || k == 89), 2'b00})
        $display("FAIL timeout cyc %0d: got %b want %b", k, soft_reset,
                 {(k == 30 || k == 89), 2'b00});
      else n_pass++;
      read_enb = (k == 58) ? 3'b100 : 3'b000;
    end
    fifo_empty = 3'b111;
    @(negedge clock);
  endtask

  task automatic test_wait_empty_and_reset();
    pkt_valid = 1'b1; data_in = 8'h09; fifo_empty = 3'b101; #1;
    n_total++;
    if ({write_enb, busy} !== 4'b0000)
      $display("FAIL wait_hdr: got %b want 0000", {write_enb, busy});
    else n_pass++;
    @(negedge clock);
    data_in = 8'h33;
    for (int k = 1; k <= 30; k++) begin
      #1;
      n_total++;
      if ({busy, write_enb, soft_reset} !== {1'b1, 3'b000, (k == 30) ? 3'b010 : 3'b000})
        $display("FAIL wait_empty cyc %0d: got %b want %b", k, {busy, write_enb, soft_reset},
                 {1'b1, 3'b000, (k == 30) ? 3'b010 : 3'b000});
      else n_pass++;
      @(negedge clock);
    end
    fifo_empty = 3'b111; #1;
    n_total++;
    if ({write_enb, dout, lfd_state, busy} !== {3'b010, 8'h09, 1'b1, 1'b1})
      $display("FAIL release_hdr: got %h want %h", {write_enb, dout, lfd_state, busy},
               {3'b010, 8'h09, 1'b1, 1'b1});
    else n_pass++;
    @(negedge clock); #1;
    n_total++;
    if ({write_enb, dout, busy} !== {3'b010, 8'h33, 1'b0})
      $display("FAIL release_data: got %h want %h", {write_enb, dout, busy},
               {3'b010, 8'h33, 1'b0});
    else n_pass++;
    @(negedge clock);
    data_in = 8'h44; resetn = 1'b0; #1;
    n_total++;
    if ({write_enb, dout} !== {3'b010, 8'h44})
      $display("FAIL pre_reset: got %h want %h", {write_enb, dout}, {3'b010, 8'h44});
    else n_pass++;
    @(negedge clock); #1;
    n_total++;
    if ({write_enb, dout, lfd_state, busy, err, soft_reset, vld_out} !== 20'h0)
      $display("FAIL mid_reset: got %h want 00000",
               {write_enb, dout, lfd_state, busy, err, soft_reset, vld_out});
    else n_pass++;
    resetn = 1'b1; pkt_valid = 1'b0;
    @(negedge clock);
    pkt_valid = 1'b1; data_in = 8'h02;
    @(negedge clock); #1;
    n_total++;
    if ({write_enb, dout, lfd_state, busy} !== {3'b100, 8'h02, 1'b1, 1'b1})
      $display("FAIL post_reset_hdr: got %h want %h", {write_enb, dout, lfd_state, busy},
               {3'b100, 8'h02, 1'b1, 1'b1});
    else n_pass++;
    @(negedge clock); #1;
    n_total++;
    if ({write_enb, dout, lfd_state, busy} !== {3'b100, 8'h02, 1'b0, 1'b0})
      $display("FAIL post_reset_par: got %h want %h", {write_enb, dout, lfd_state, busy},
               {3'b100, 8'h02, 1'b0, 1'b0});
    else n_pass++;
    pkt_valid = 1'b0;
    @(negedge clock); #1;
    n_total++;
    if ({write_enb, err} !== 4'b0000)
      $display("FAIL post_reset_err: got %b want 0000", {write_enb, err});
    else n_pass++;
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
    fifo_full = 3'b000; fifo_empty = 3'b111; read_enb = 3'b000;
    @(negedge clock);
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_bad_addr_drop();
    test_back_pressure();
    test_timeout();
    test_wait_empty_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
